// File: rtl/gbe_fifo_pkg.sv
// Shared widths, depths and control-word layout for the GbE UDP transmit FIFOs.
// The control word is {size[15:0], dest_port[15:0], dest_ip[31:0]}.
package gbe_fifo_pkg;

  localparam int PKT_FIFO_WIDTH        = 8;
  localparam int CTRL_FIFO_WIDTH       = 64;

  localparam int PKT_ADDR_WIDTH        = 12;
  localparam int CTRL_ADDR_WIDTH       = 9;
  localparam int PKT_PROG_FULL_THRESH  = 3072;
  localparam int CTRL_PROG_FULL_THRESH = 384;

  localparam int CTRL_SIZE_MSB = 63;
  localparam int CTRL_SIZE_LSB = 48;
  localparam int CTRL_PORT_MSB = 47;
  localparam int CTRL_PORT_LSB = 32;
  localparam int CTRL_IP_MSB   = 31;
  localparam int CTRL_IP_LSB   = 0;

  typedef struct packed {
    logic [15:0] size;
    logic [15:0] dest_port;
    logic [31:0] dest_ip;
  } ctrl_word_t;

endpackage

// File: rtl/gbe_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous (combinational) read.
// Latency: write visible on read port after the write edge; no backpressure.
// Contents are never reset.
module gbe_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/gbe_tx_sync_fifo.sv
// Single-clock FWFT FIFO for the GbE UDP TX path; GBE_FIFO_DATA_COUNT_EN adds data_count.
// Latency: one cycle write-to-dout; flags decode the registered count.
// Backpressure: prog_full at threshold; writes while full (no pop) are dropped with an overflow pulse.
module gbe_tx_sync_fifo
  import gbe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = PKT_FIFO_WIDTH,
  parameter int ADDR_WIDTH       = PKT_ADDR_WIDTH,
  parameter int PROG_FULL_THRESH = PKT_PROG_FULL_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  prog_full,
  output logic                  empty,
  output logic                  overflow
`ifdef GBE_FIFO_DATA_COUNT_EN
  ,output logic [ADDR_WIDTH:0]  data_count
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] THRESH_C = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign prog_full = (count >= THRESH_C);

  // A pop frees the slot this cycle, so a write into a full FIFO is still taken.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + (ADDR_WIDTH+1)'(1);
      2'b01:   count_nxt = count - (ADDR_WIDTH+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count    <= count_nxt;
      overflow <= wr_en && full && !rd_acc;
    end
  end

`ifdef GBE_FIFO_DATA_COUNT_EN
  assign data_count = count;
`endif

  gbe_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_dat  (din),
    .rd_addr (rd_ptr),
    .rd_dat  (dout)
  );

endmodule

// File: tb/tb_gbe_tx_sync_fifo.sv
// Bench for gbe_tx_sync_fifo: byte FIFO (depth 16, threshold 12) against a queue model,
// plus a 64-bit control-word instance.
module tb_gbe_tx_sync_fifo;
  import gbe_fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int THRESH = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          prog_full, empty, overflow;

  logic [63:0]   c_din = '0;
  logic          c_wr = 1'b0;
  logic          c_rd = 1'b0;
  logic [63:0]   c_dout;
  logic          c_prog_full, c_empty, c_overflow;

`ifdef GBE_FIFO_DATA_COUNT_EN
  logic [AW:0]   data_count;
  logic [AW:0]   c_data_count;
`endif

  always #5 clk = ~clk;

  gbe_tx_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_FULL_THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .dout(dout), .rd_en(rd_en),
    .prog_full(prog_full), .empty(empty), .overflow(overflow)
`ifdef GBE_FIFO_DATA_COUNT_EN
    , .data_count(data_count)
`endif
  );

  gbe_tx_sync_fifo #(.DATA_WIDTH(64), .ADDR_WIDTH(AW), .PROG_FULL_THRESH(THRESH)) dut_ctrl (
    .clk(clk), .rst_n(rst_n), .din(c_din), .wr_en(c_wr), .dout(c_dout), .rd_en(c_rd),
    .prog_full(c_prog_full), .empty(c_empty), .overflow(c_overflow)
`ifdef GBE_FIFO_DATA_COUNT_EN
    , .data_count(c_data_count)
`endif
  );

  int          n_checks = 0;
  int          n_fail = 0;
  string       phase = "init";
  logic [7:0]  q[$];        // reference model contents, head at index 0
  logic [7:0]  pop_log[$];  // every word the model expects to be popped
  logic [7:0]  in_seq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_flags();
    check("empty", empty, q.size() == 0);
    check("prog_full", prog_full, q.size() >= THRESH);
    if (q.size() > 0) check("head", dout, q[0]);
`ifdef GBE_FIFO_DATA_COUNT_EN
    check("data_count", data_count, q.size());
`endif
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
    logic rd_acc, wr_acc, exp_ovf;
    rd_acc  = rd && (q.size() > 0);
    wr_acc  = wr && ((q.size() < DEPTH) || rd_acc);
    exp_ovf = wr && (q.size() == DEPTH) && !rd_acc;
    wr_en = wr; din = d; rd_en = rd;
    #1;
    if (rd_acc) check("pop_dat", dout, q[0]);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (rd_acc) pop_log.push_back(q.pop_front());
    if (wr_acc) q.push_back(d);
    check("overflow", overflow, exp_ovf);
    check_flags();
  endtask

  initial begin
    ctrl_word_t cw;
    int written, guard;
    logic wr, rd;
    logic [7:0] d;

    // 1. asynchronous reset asserted between edges
    phase = "reset";
    #3 rst_n = 1'b0;
    #1;
    check("empty", empty, 1'b1);
    check("prog_full", prog_full, 1'b0);
    check("overflow", overflow, 1'b0);
    check("c_empty", c_empty, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete();
    check_flags();
    check("overflow", overflow, 1'b0);

    // 2. first-word fall-through
    phase = "fwft";
    cycle(1'b1, 8'hA5, 1'b0);
    check("dout", dout, 8'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    check("empty_after_pop", empty, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);  // pop while empty is ignored

    // 3. fill, overflow, drain
    phase = "fill";
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    check("prog_full_at_16", prog_full, 1'b1);
    cycle(1'b1, 8'h10, 1'b0);
    check("ovf_pulse", overflow, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("ovf_cleared", overflow, 1'b0);
    pop_log.delete();
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drain_cnt", pop_log.size(), 16);
    for (int i = 0; i < pop_log.size(); i++) check("drain_order", pop_log[i], 8'(i));
    check("drained_empty", empty, 1'b1);

    // 4. full with simultaneous read and write
    phase = "full_rw";
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    check("no_ovf", overflow, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);  // still full, so this one is dropped
    check("still_full_ovf", overflow, 1'b1);
    pop_log.delete();
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    check("last_word", pop_log[pop_log.size()-1], 8'h55);
    check("first_word", pop_log[0], 8'h21);

    // 5. random interleave across pointer wrap
    phase = "wrap";
    pop_log.delete();
    in_seq.delete();
    written = 0;
    guard = 0;
    while (written < 40 && guard < 2000) begin
      wr = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 2) == 0);
      if (wr && q.size() == DEPTH) rd = 1'b1;
      d = 8'($urandom);
      if (wr) begin
        in_seq.push_back(d);
        written++;
      end
      cycle(wr, d, rd);
      guard++;
    end
    while (q.size() > 0 && guard < 2000) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    check("written", written, 40);
    check("popped", pop_log.size(), in_seq.size());
    for (int i = 0; i < in_seq.size() && i < pop_log.size(); i++)
      check("stream", pop_log[i], in_seq[i]);

    // reset in the middle of a full FIFO with overflow pending
    phase = "mid_reset";
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    check("pre_ovf", overflow, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    check("empty", empty, 1'b1);
    check("prog_full", prog_full, 1'b0);
    check("overflow", overflow, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_flags();
    cycle(1'b1, 8'h3C, 1'b0);
    check("post_reset_dout", dout, 8'h3C);
    cycle(1'b0, 8'h00, 1'b1);

    // 6. control-word width
    phase = "ctrl";
    check("c_empty0", c_empty, 1'b1);
    cw.size = 16'd10;
    cw.dest_port = 16'd7148;
    cw.dest_ip = 32'h0A000001;
    c_din = cw;
    c_wr = 1'b1;
    @(posedge clk); #1;
    c_wr = 1'b0;
    check("c_empty1", c_empty, 1'b0);
    check("c_size", c_dout[CTRL_SIZE_MSB:CTRL_SIZE_LSB], 16'd10);
    check("c_port", c_dout[CTRL_PORT_MSB:CTRL_PORT_LSB], 16'd7148);
    check("c_ip", c_dout[CTRL_IP_MSB:CTRL_IP_LSB], 32'h0A000001);
    c_rd = 1'b1;
    @(posedge clk); #1;
    c_rd = 1'b0;
    check("c_empty2", c_empty, 1'b1);
    check("c_ovf", c_overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
